julia_frame_sweeper: RTL and testbench

Parametrised successor to the single-zoom Julia BRAM controller. Sweeps every pixel of an H_RES x V_RES frame and maps each pixel to a Q16.16 complex coordinate, using incremental stepping with no divider. Drives the iteration engine through a start/done handshake, quantises the iteration count to PIX_BITS, and writes the result to the frame buffer. Adds N zoom levels, panning, restart-on-change and continuous re-rendering. Sits between button debounce/edge logic and the dual-port frame BRAM (write port A).

---
 rtl/julia_frame_sweeper.sv | 226 ++++++++++++++++++++++
 tb/tb_julia_frame_sweeper.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/julia_frame_sweeper.sv
// Julia frame sweeper: maps each frame pixel to a Q16.16 coordinate, runs it through the iteration
// engine and writes the quantised count to the frame buffer; zoom/pan changes restart the sweep.
module julia_frame_sweeper #(
    parameter int unsigned H_RES       = 1280,
    parameter int unsigned V_RES       = 720,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned PIX_BITS    = 4,
    parameter int unsigned ITER_W      = 9,
    parameter int unsigned MAX_ITER    = 256,
    parameter int unsigned ZOOM_LEVELS = 4,
    parameter int          STEP_X0     = 410,
    parameter int          STEP_Y0     = 410,
    parameter int unsigned PAN_PIX     = 64,
    parameter int          CENTER_LIM  = 32'h0004_0000,
    parameter bit          CONTINUOUS  = 1'b1,
    localparam int unsigned ZW         = (ZOOM_LEVELS > 1) ? $clog2(ZOOM_LEVELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                zoom_in,
    input  logic                zoom_out,
    input  logic [3:0]          pan,
    output logic                eng_start,
    output logic [31:0]         eng_x,
    output logic [31:0]         eng_y,
    input  logic                eng_done,
    input  logic [ITER_W-1:0]   eng_iter,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [PIX_BITS-1:0] fb_data,
    output logic                frame_done,
    output logic [ZW-1:0]       zoom_level,
    output logic                busy
);

    localparam int unsigned XW   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW   = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned QSH  = $clog2(MAX_ITER) - PIX_BITS;
    localparam int unsigned PMAX = (2 ** PIX_BITS) - 1;

    localparam logic signed [31:0] STEP_X = 32'(STEP_X0);
    localparam logic signed [31:0] STEP_Y = 32'(STEP_Y0);
    localparam logic signed [31:0] PAN_S  = 32'(PAN_PIX);
    localparam logic signed [47:0] HALF_W = 48'(H_RES / 2);
    localparam logic signed [47:0] HALF_H = 48'(V_RES / 2);
    localparam logic signed [33:0] LIM    = 34'(CENTER_LIM);
    localparam logic [ZW-1:0]      ZMAX   = ZW'(ZOOM_LEVELS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    state_t               state, state_next;
    logic signed [31:0]   cx, cy, cx_n, cy_n;
    logic [ZW-1:0]        zoom_n;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic                 restart_pending;
    logic signed [31:0]   sx, sy, dx, dy, x0, y0;
    logic signed [47:0]   x0_off, y0_off;
    logic signed [33:0]   cx_sum, cy_sum;
    logic                 view_change;
    logic                 last_pix;
    logic                 do_restart, do_advance, do_capture, done_c;
    logic [ITER_W-1:0]    iter_sh;
    logic [PIX_BITS-1:0]  quant;

    function automatic logic signed [31:0] clamp(input logic signed [33:0] v);
        if (v > LIM)       return LIM[31:0];
        else if (v < -LIM) return -LIM[31:0];
        else               return v[31:0];
    endfunction

    // Steps, frame origin and pan deltas at the current zoom level
    always_comb begin
        sx     = STEP_X >>> zoom_level;
        sy     = STEP_Y >>> zoom_level;
        x0_off = 48'(sx) * HALF_W;
        y0_off = 48'(sy) * HALF_H;
        x0     = cx - x0_off[31:0];
        y0     = cy + y0_off[31:0];
        dx     = sx * PAN_S;
        dy     = sy * PAN_S;
    end

    // View update: opposite pulses cancel, centre saturates, pan uses the pre-zoom step
    always_comb begin
        cx_n   = cx;
        cy_n   = cy;
        zoom_n = zoom_level;
        cx_sum = '0;
        cy_sum = '0;
        if (pan[0] ^ pan[1]) begin
            cx_sum = pan[1] ? (34'(cx) + 34'(dx)) : (34'(cx) - 34'(dx));
            cx_n   = clamp(cx_sum);
        end
        if (pan[2] ^ pan[3]) begin
            cy_sum = pan[2] ? (34'(cy) + 34'(dy)) : (34'(cy) - 34'(dy));
            cy_n   = clamp(cy_sum);
        end
        if (zoom_in && !zoom_out && (zoom_level != ZMAX))
            zoom_n = zoom_level + ZW'(1);
        else if (zoom_out && !zoom_in && (zoom_level != '0))
            zoom_n = zoom_level - ZW'(1);
        view_change = (cx_n != cx) || (cy_n != cy) || (zoom_n != zoom_level);
    end

    always_comb begin
        iter_sh = eng_iter >> QSH;
        quant   = (iter_sh > ITER_W'(PMAX)) ? PIX_BITS'(PMAX) : iter_sh[PIX_BITS-1:0];
    end

    assign last_pix = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_restart = 1'b0;
        do_advance = 1'b0;
        do_capture = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (restart_pending) begin
                    state_next = ISSUE;
                    do_restart = 1'b1;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // A pending view change discards the in-flight result
                if (eng_done) begin
                    if (restart_pending) begin
                        state_next = ISSUE;
                        do_restart = 1'b1;
                    end else begin
                        state_next = WRITE;
                        do_capture = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (restart_pending) begin
                    state_next = ISSUE;
                    do_restart = 1'b1;
                end else if (last_pix) begin
                    done_c = 1'b1;
                    if (CONTINUOUS) begin
                        state_next = ISSUE;
                        do_restart = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = ISSUE;
                    do_advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs track the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_start  <= 1'b0;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            fb_data    <= '0;
        end else begin
            eng_start  <= (state_next == ISSUE);
            fb_we      <= do_capture;
            frame_done <= done_c;
            busy       <= (state_next != IDLE);
            if (do_capture) fb_data <= quant;
        end
    end

    // Pixel walk with incremental coordinate stepping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x       <= '0;
            y       <= '0;
            fb_addr <= '0;
            eng_x   <= '0;
            eng_y   <= '0;
        end else if (do_restart) begin
            x       <= '0;
            y       <= '0;
            fb_addr <= '0;
            eng_x   <= x0;
            eng_y   <= y0;
        end else if (do_advance) begin
            fb_addr <= fb_addr + ADDR_W'(1);
            if (x == XW'(H_RES - 1)) begin
                x     <= '0;
                y     <= y + YW'(1);
                eng_x <= x0;
                eng_y <= eng_y - sy;
            end else begin
                x     <= x + XW'(1);
                eng_x <= eng_x + sx;
            end
        end
    end

    // Leaving reset counts as a pending change so the first sweep starts on its own
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx              <= '0;
            cy              <= '0;
            zoom_level      <= '0;
            restart_pending <= 1'b1;
        end else begin
            cx         <= cx_n;
            cy         <= cy_n;
            zoom_level <= zoom_n;
            if (view_change)     restart_pending <= 1'b1;
            else if (do_restart) restart_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_julia_frame_sweeper.sv
// Directed bench for julia_frame_sweeper on an 8x4 frame: continuous instance (a) and one-shot
// instance (b), each served by a fixed-latency engine model.
module tb_julia_frame_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        zoom_in_a = 1'b0, zoom_out_a = 1'b0, zoom_in_b = 1'b0, zoom_out_b = 1'b0;
    logic [3:0]  pan_a = 4'd0, pan_b = 4'd0;
    logic        eng_start_a, eng_start_b, eng_done_a, eng_done_b;
    logic [31:0] eng_x_a, eng_y_a, eng_x_b, eng_y_b;
    logic [8:0]  eng_iter_a, eng_iter_b;
    logic        fb_we_a, fb_we_b, frame_done_a, frame_done_b, busy_a, busy_b;
    logic [19:0] fb_addr_a, fb_addr_b;
    logic [3:0]  fb_data_a, fb_data_b;
    logic [1:0]  zoom_level_a, zoom_level_b;

    julia_frame_sweeper #(.H_RES(8), .V_RES(4), .CONTINUOUS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .zoom_in(zoom_in_a), .zoom_out(zoom_out_a), .pan(pan_a),
        .eng_start(eng_start_a), .eng_x(eng_x_a), .eng_y(eng_y_a), .eng_done(eng_done_a),
        .eng_iter(eng_iter_a), .fb_we(fb_we_a), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
        .frame_done(frame_done_a), .zoom_level(zoom_level_a), .busy(busy_a));

    julia_frame_sweeper #(.H_RES(8), .V_RES(4), .CONTINUOUS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .zoom_in(zoom_in_b), .zoom_out(zoom_out_b), .pan(pan_b),
        .eng_start(eng_start_b), .eng_x(eng_x_b), .eng_y(eng_y_b), .eng_done(eng_done_b),
        .eng_iter(eng_iter_b), .fb_we(fb_we_b), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
        .frame_done(frame_done_b), .zoom_level(zoom_level_b), .busy(busy_b));

    // Engine models: done pulse a fixed number of cycles after start
    logic [8:0] iter_a = 9'd200, iter_b = 9'd100;
    int   cnt_a, cnt_b;
    logic pend_a, pend_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_a <= 1'b0; cnt_a <= 0; eng_done_a <= 1'b0; eng_iter_a <= '0;
        end else begin
            eng_done_a <= 1'b0;
            if (eng_start_a) begin
                pend_a <= 1'b1; cnt_a <= 4;
            end else if (pend_a) begin
                if (cnt_a == 0) begin
                    pend_a <= 1'b0; eng_done_a <= 1'b1; eng_iter_a <= iter_a;
                end else cnt_a <= cnt_a - 1;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_b <= 1'b0; cnt_b <= 0; eng_done_b <= 1'b0; eng_iter_b <= '0;
        end else begin
            eng_done_b <= 1'b0;
            if (eng_start_b) begin
                pend_b <= 1'b1; cnt_b <= 4;
            end else if (pend_b) begin
                if (cnt_b == 0) begin
                    pend_b <= 1'b0; eng_done_b <= 1'b1; eng_iter_b <= iter_b;
                end else cnt_b <= cnt_b - 1;
            end
        end
    end

    int wr_cnt_a = 0, wr_cnt_b = 0, fd_cnt_b = 0, st_cnt_b = 0;
    always @(posedge clk) begin
        if (fb_we_a)      wr_cnt_a <= wr_cnt_a + 1;
        if (fb_we_b)      wr_cnt_b <= wr_cnt_b + 1;
        if (frame_done_b) fd_cnt_b <= fd_cnt_b + 1;
        if (eng_start_b)  st_cnt_b <= st_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic wait_for(input int sel, input string tag);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge clk);
            case (sel)
                0:       hit = eng_start_a;
                1:       hit = fb_we_a;
                2:       hit = eng_start_b;
                default: hit = fb_we_b;
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    // Sync on an engine start of dut_a, then pulse view inputs while it waits on the engine
    task automatic view_pulse_a(input logic zi, input logic zo, input logic [3:0] p,
                                output logic [31:0] addr_at);
        wait_for(0, "pulse_sync");
        addr_at = 32'(fb_addr_a);
        @(negedge clk);
        zoom_in_a = zi; zoom_out_a = zo; pan_a = p;
        @(negedge clk);
        zoom_in_a = 1'b0; zoom_out_a = 1'b0; pan_a = 4'd0;
    endtask

    initial begin
        logic [8:0]  itab [8];
        logic [31:0] qtab [8];
        logic [31:0] at;
        int          w0, s0, exp_cx;
        itab = '{9'd200, 9'd256, 9'd15, 9'd16, 9'd240, 9'd255, 9'd0, 9'd100};
        qtab = '{32'd12, 32'd15, 32'd0, 32'd1, 32'd15, 32'd15, 32'd0, 32'd6};

        #3 rst = 1'b0;
        @(negedge clk);
        check("rst_eng_start", 32'(eng_start_a), 32'd0);
        check("rst_busy",      32'(busy_a), 32'd0);
        check("rst_fb_we",     32'(fb_we_a), 32'd0);
        check("rst_fb_addr",   32'(fb_addr_a), 32'd0);
        check("rst_eng_x",     eng_x_a, 32'd0);
        check("rst_zoom",      32'(zoom_level_a), 32'd0);
        check("rst_b_busy",    32'(busy_b), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First frame: coordinates, addresses and quantisation per pixel
        for (int i = 0; i < 32; i++) begin
            wait_for(0, "start");
            check("eng_x", eng_x_a, 32'(-1640 + 410 * (i % 8)));
            check("eng_y", eng_y_a, 32'(820 - 410 * (i / 8)));
            check("busy",  32'(busy_a), 32'd1);
            iter_a = itab[i % 8];
            wait_for(1, "write");
            check("fb_addr", 32'(fb_addr_a), 32'(i));
            check("fb_data", 32'(fb_data_a), qtab[i % 8]);
        end
        @(negedge clk);
        check("frame_done",     32'(frame_done_a), 32'd1);
        check("new_frame_start", 32'(eng_start_a), 32'd1);
        check("new_frame_x",    eng_x_a, 32'(-1640));
        check("new_frame_addr", 32'(fb_addr_a), 32'd0);
        iter_a = 9'd50;
        wait_for(1, "f2_write0");
        check("frame_done_low", 32'(frame_done_a), 32'd0);

        // Two zoom_in pulses while waiting on the engine: result dropped, restart at zoom 2
        wait_for(0, "f2_start1");
        w0 = wr_cnt_a;
        @(negedge clk); zoom_in_a = 1'b1;
        @(negedge clk); zoom_in_a = 1'b0;
        @(negedge clk); zoom_in_a = 1'b1;
        @(negedge clk); zoom_in_a = 1'b0;
        wait_for(0, "zoom_restart");
        check("zoom_no_write", 32'(wr_cnt_a), 32'(w0));
        check("zoom_eng_x",    eng_x_a, 32'(-408));
        check("zoom_eng_y",    eng_y_a, 32'd204);
        check("zoom_level2",   32'(zoom_level_a), 32'd2);
        check("zoom_addr",     32'(fb_addr_a), 32'd0);

        view_pulse_a(1'b0, 1'b1, 4'd0, at); check("zoom_out_1",     32'(zoom_level_a), 32'd1);
        view_pulse_a(1'b0, 1'b1, 4'd0, at); check("zoom_out_0",     32'(zoom_level_a), 32'd0);
        view_pulse_a(1'b0, 1'b1, 4'd0, at); check("zoom_out_floor", 32'(zoom_level_a), 32'd0);
        view_pulse_a(1'b1, 1'b1, 4'd0, at); check("zoom_both",      32'(zoom_level_a), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            view_pulse_a(1'b1, 1'b0, 4'd0, at);
            check("zoom_in_sat", 32'(zoom_level_a), 32'((k > 3) ? 3 : k));
        end
        for (int k = 1; k <= 3; k++) begin
            view_pulse_a(1'b0, 1'b1, 4'd0, at);
            check("zoom_back", 32'(zoom_level_a), 32'(3 - k));
        end

        // Pan right until the centre saturates
        for (int k = 1; k <= 10; k++) begin
            view_pulse_a(1'b0, 1'b0, 4'b0010, at);
            wait_for(0, "pan_restart");
            exp_cx = (26240 * k > 262144) ? 262144 : 26240 * k;
            check("pan_x",    eng_x_a, 32'(exp_cx - 1640));
            check("pan_addr", 32'(fb_addr_a), 32'd0);
        end

        // Left and right together: no change, pixel still written
        wait_for(1, "pre_cancel_write");
        view_pulse_a(1'b0, 1'b0, 4'b0011, at);
        check("cancel_sync_addr", at, 32'd1);
        wait_for(1, "cancel_write");
        check("cancel_addr", 32'(fb_addr_a), 32'd1);

        view_pulse_a(1'b0, 1'b0, 4'b0100, at);
        wait_for(0, "up_restart");
        check("up_eng_y", eng_y_a, 32'd27060);
        check("up_eng_x", eng_x_a, 32'd260504);
        check("up_addr",  32'(fb_addr_a), 32'd0);

        // Pan left with zoom_in: pan uses the level-0 step
        view_pulse_a(1'b1, 1'b0, 4'b0001, at);
        wait_for(0, "panzoom_restart");
        check("panzoom_x",    eng_x_a, 32'd235084);
        check("panzoom_y",    eng_y_a, 32'd26650);
        check("panzoom_zoom", 32'(zoom_level_a), 32'd1);

        // One-shot instance: single frame, then idle until a view change
        check("b_writes",     32'(wr_cnt_b), 32'd32);
        check("b_frame_done", 32'(fd_cnt_b), 32'd1);
        check("b_busy_idle",  32'(busy_b), 32'd0);
        check("b_last_data",  32'(fb_data_b), 32'd6);
        s0 = st_cnt_b;
        repeat (20) @(negedge clk);
        check("b_no_start", 32'(st_cnt_b), 32'(s0));
        pan_b = 4'b0010;
        @(negedge clk);
        pan_b = 4'd0;
        wait_for(2, "b_restart");
        check("b_restart_x",    eng_x_b, 32'd24600);
        check("b_restart_busy", 32'(busy_b), 32'd1);
        check("b_restart_addr", 32'(fb_addr_b), 32'd0);

        // Asynchronous reset while waiting on the engine
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_b_start", 32'(eng_start_b), 32'd0);
        check("arst_b_x",     eng_x_b, 32'd0);
        check("arst_b_busy",  32'(busy_b), 32'd0);
        check("arst_b_data",  32'(fb_data_b), 32'd0);
        check("arst_a_zoom",  32'(zoom_level_a), 32'd0);
        check("arst_a_y",     eng_y_a, 32'd0);
        check("arst_a_busy",  32'(busy_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
